// File: rtl/spike_gen_array_pkg.sv
// Shared definitions for the spike generator array: sweep states and default widths.
package spike_gen_array_pkg;

    localparam int unsigned NGENS_DEF   = 8;
    localparam int unsigned NPERIOD_DEF = 16;
    localparam int unsigned NTAG_DEF    = 11;
    localparam int unsigned NCT_DEF     = 10;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WAIT,
        WB
    } state_t;

    // Stored word is {tick, period, tag}.
    function automatic int unsigned gen_word_width(input int unsigned nperiod,
                                                   input int unsigned ntag);
        return 2 * nperiod + ntag;
    endfunction

endpackage

// File: rtl/spike_gen_mem.sv
// Simple dual-port generator state RAM: one write port, one read port with
// registered address and registered output (two-cycle read).
module spike_gen_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned DW    = 43
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] raddr_q;
    logic          re_q;

    // Output register loads only on the cycle after a read request, so read
    // data holds while the consumer stalls and after it writes the entry back.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        re_q <= re;
        if (re) begin
            raddr_q <= raddr;
        end
        if (re_q) begin
            rdata <= mem[raddr_q];
        end
    end

endmodule

// File: rtl/spike_gen_array.sv
// Array of programmable periodic spike generators, time-multiplexed over one
// RAM and swept once per unit_pulse; spikes leave on a valid/ack channel.
module spike_gen_array
    import spike_gen_array_pkg::*;
#(
    parameter  int unsigned NGENS   = NGENS_DEF,
    parameter  int unsigned NPERIOD = NPERIOD_DEF,
    parameter  int unsigned NTAG    = NTAG_DEF,
    parameter  int unsigned NCT     = NCT_DEF,
    localparam int unsigned IW      = $clog2(NGENS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               unit_pulse,
    input  logic [IW:0]        gens_used,
    input  logic [NGENS-1:0]   gens_en,
    input  logic               prog_v,
    output logic               prog_a,
    input  logic [IW-1:0]      prog_gen_idx,
    input  logic [NPERIOD-1:0] prog_ticks,
    input  logic [NPERIOD-1:0] prog_period,
    input  logic [NTAG-1:0]    prog_tag,
    output logic               out_v,
    input  logic               out_a,
    output logic [NTAG-1:0]    out_tag,
    output logic [NCT-1:0]     out_ct
);

    localparam int unsigned DW = gen_word_width(NPERIOD, NTAG);

    state_t          state;
    logic [IW-1:0]   idx;
    logic [IW:0]     idx_next;
    logic            last;

    logic            mem_we;
    logic [IW-1:0]   mem_waddr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_re;
    logic [DW-1:0]   mem_rdata;

    logic [NPERIOD-1:0] rd_tick;
    logic [NPERIOD-1:0] rd_period;
    logic [NTAG-1:0]    rd_tag;
    logic [NPERIOD-1:0] new_tick;
    logic               spike;
    logic               wb_done;

    assign rd_tick   = mem_rdata[DW-1 -: NPERIOD];
    assign rd_period = mem_rdata[NTAG +: NPERIOD];
    assign rd_tag    = mem_rdata[NTAG-1:0];

    assign spike    = !(rd_tick < rd_period);
    assign new_tick = spike ? NPERIOD'(1) : rd_tick + NPERIOD'(1);

    assign idx_next = {1'b0, idx} + (IW+1)'(1);
    assign last     = !(idx_next < gens_used);

    // Write-back happens once, on the cycle the generator is released.
    assign wb_done = (state == WB) && (!spike || out_a);

    assign prog_a = reset && (state == IDLE) && prog_v;

    assign out_v   = (state == WB) && spike;
    assign out_tag = out_v ? rd_tag : '0;
    assign out_ct  = out_v ? NCT'(1) : '0;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = idx;
        mem_wdata = {new_tick, rd_period, rd_tag};
        if (prog_a) begin
            mem_we    = 1'b1;
            mem_waddr = prog_gen_idx;
            mem_wdata = {prog_ticks, prog_period, prog_tag};
        end else if (wb_done) begin
            mem_we    = 1'b1;
        end
    end

    assign mem_re = (state == RD) && gens_en[idx];

    spike_gen_mem #(
        .DEPTH (NGENS),
        .AW    (IW),
        .DW    (DW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (mem_re),
        .raddr (idx),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (unit_pulse) begin
                        idx <= '0;
                        if (gens_used != '0) begin
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    if (gens_en[idx]) begin
                        state <= WAIT;
                    end else if (last) begin
                        state <= IDLE;
                    end else begin
                        idx <= idx_next[IW-1:0];
                    end
                end
                WAIT: begin
                    state <= WB;
                end
                WB: begin
                    if (wb_done) begin
                        if (last) begin
                            state <= IDLE;
                        end else begin
                            idx   <= idx_next[IW-1:0];
                            state <= RD;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_gen_array.sv
// Randomized self-checking bench for spike_gen_array against a per-sweep reference model.
module tb_spike_gen_array;

    localparam int unsigned NG = 8;
    localparam int unsigned NP = 16;
    localparam int unsigned NT = 11;
    localparam int unsigned NC = 10;
    localparam int unsigned IW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          unit_pulse;
    logic [IW:0]   gens_used;
    logic [NG-1:0] gens_en;
    logic          prog_v;
    logic          prog_a;
    logic [IW-1:0] prog_gen_idx;
    logic [NP-1:0] prog_ticks;
    logic [NP-1:0] prog_period;
    logic [NT-1:0] prog_tag;
    logic          out_v;
    logic          out_a;
    logic [NT-1:0] out_tag;
    logic [NC-1:0] out_ct;

    spike_gen_array #(
        .NGENS   (NG),
        .NPERIOD (NP),
        .NTAG    (NT),
        .NCT     (NC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .unit_pulse   (unit_pulse),
        .gens_used    (gens_used),
        .gens_en      (gens_en),
        .prog_v       (prog_v),
        .prog_a       (prog_a),
        .prog_gen_idx (prog_gen_idx),
        .prog_ticks   (prog_ticks),
        .prog_period  (prog_period),
        .prog_tag     (prog_tag),
        .out_v        (out_v),
        .out_a        (out_a),
        .out_tag      (out_tag),
        .out_ct       (out_ct)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: one entry per generator, plain integers.
    int unsigned m_tick   [NG];
    int unsigned m_period [NG];
    int unsigned m_tag    [NG];
    int unsigned exp_q    [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_write(input int unsigned i, input int unsigned t,
                                        input int unsigned p, input int unsigned g);
        m_tick[i]   = t;
        m_period[i] = p;
        m_tag[i]    = g;
    endfunction

    // One full sweep: every counted, enabled generator advances; spikes queue their tags.
    function automatic void model_sweep();
        for (int i = 0; i < int'(gens_used); i++) begin
            if (gens_en[i]) begin
                if (m_tick[i] < m_period[i]) begin
                    m_tick[i] = m_tick[i] + 1;
                end else begin
                    m_tick[i] = 1;
                    exp_q.push_back(m_tag[i]);
                end
            end
        end
    endfunction

    task automatic program_gen(input int unsigned i, input int unsigned t,
                               input int unsigned p, input int unsigned g);
        @(negedge clk);
        prog_v       = 1'b1;
        prog_gen_idx = IW'(i);
        prog_ticks   = NP'(t);
        prog_period  = NP'(p);
        prog_tag     = NT'(g);
        #1;
        check_eq("prog_a_idle", 32'(prog_a), 32'd1);
        @(negedge clk);
        prog_v = 1'b0;
        model_write(i, t, p, g);
    endtask

    task automatic run_sweep(input bit do_prog, input int unsigned maxdly, input bit check_lat);
        int          cyc;
        int          tail;
        int          spike_k;
        int unsigned dly;
        bit          stalled;
        bit          prog_pending;
        bit          accepted;
        logic [NT-1:0] prev_tag;
        int unsigned pi, pt, pp, pg;
        int unsigned exp_tag;

        cyc = 0; tail = -1; spike_k = 0; stalled = 0; accepted = 0;
        prev_tag = '0;
        prog_pending = do_prog;
        pi = $urandom_range(NG - 1, 0);
        pp = $urandom_range(5, 0);
        pt = $urandom_range(pp, 0);
        pg = $urandom_range(2047, 0);

        @(negedge clk);
        unit_pulse = 1'b1;
        model_sweep();
        @(negedge clk);
        unit_pulse = 1'b0;
        dly = $urandom_range(maxdly, 0);
        if (do_prog) begin
            prog_v       = 1'b1;
            prog_gen_idx = IW'(pi);
            prog_ticks   = NP'(pt);
            prog_period  = NP'(pp);
            prog_tag     = NT'(pg);
        end

        while (cyc < 600) begin
            #1;
            if (prog_pending && !accepted) begin
                if (exp_q.size() > 0) check_eq("prog_stall", 32'(prog_a), 32'd0);
                if (prog_a) accepted = 1;
            end
            if (out_v) begin
                check_eq("out_ct", 32'(out_ct), 32'd1);
                if (stalled) check_eq("stall_tag", 32'(out_tag), 32'(prev_tag));
                if (dly == 0) begin
                    out_a = 1'b1;
                    check_eq("spike_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        exp_tag = exp_q.pop_front();
                        check_eq("spike_tag", 32'(out_tag), exp_tag);
                    end
                    if (check_lat) check_eq("spike_cycle", 32'(cyc), 32'(2 + 3 * spike_k));
                    spike_k++;
                    stalled = 0;
                    dly = $urandom_range(maxdly, 0);
                end else begin
                    out_a = 1'b0;
                    dly--;
                    stalled = 1;
                    prev_tag = out_tag;
                end
            end else begin
                out_a = 1'b0;
                check_eq("idle_out", 32'({out_tag, out_ct}), 32'd0);
            end
            @(negedge clk);
            cyc++;
            if (prog_pending && accepted) begin
                prog_v = 1'b0;
                model_write(pi, pt, pp, pg);
                prog_pending = 0;
            end
            if (exp_q.size() == 0 && tail < 0) tail = cyc + 3 * int'(gens_used) + 3;
            if (tail >= 0 && cyc >= tail && !prog_pending) break;
        end
        out_a  = 1'b0;
        prog_v = 1'b0;
        check_eq("sweep_left", 32'(exp_q.size()), 32'd0);
        if (do_prog) check_eq("prog_taken", 32'(prog_pending), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int unsigned exp_tag;
        bit seen;

        reset = 1'b0; unit_pulse = 1'b0; gens_used = '0; gens_en = '0;
        prog_v = 1'b1; prog_gen_idx = '0; prog_ticks = '0; prog_period = '0;
        prog_tag = '0; out_a = 1'b0;
        #1;
        check_eq("rst_prog_a", 32'(prog_a), 32'd0);
        check_eq("rst_out_v", 32'(out_v), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("rst_out_v_hold", 32'(out_v), 32'd0);
        prog_v = 1'b0;
        reset  = 1'b1;

        // Two-generator cadence: 512 every 2nd pulse, 513 every 4th.
        program_gen(0, 0, 2, 512);
        program_gen(1, 2, 4, 513);
        gens_used = 4'd2;
        gens_en   = 8'h03;
        for (int n = 0; n < 10; n++) run_sweep(0, 3, 0);

        gens_en = 8'h02;
        for (int n = 0; n < 8; n++) run_sweep(0, 10, 0);

        // Empty sweep, then period-0 generators with exact cycle timing.
        gens_used = '0;
        gens_en   = 8'hFF;
        run_sweep(0, 0, 0);
        program_gen(0, 0, 0, 100);
        program_gen(1, 0, 0, 101);
        gens_used = 4'd2;
        gens_en   = 8'h03;
        for (int n = 0; n < 3; n++) run_sweep(0, 0, 1);

        // Random population, random stalls, programming raised mid-sweep.
        for (int i = 0; i < int'(NG); i++) begin
            int unsigned p;
            p = $urandom_range(5, 0);
            program_gen(i, $urandom_range(p, 0), p, $urandom_range(2047, 0));
        end
        for (int n = 0; n < 24; n++) begin
            gens_used = IW'(0) + (IW+1)'($urandom_range(NG, 0));
            gens_en   = NG'($urandom);
            run_sweep(($urandom_range(2, 0) == 0), 10, 0);
        end

        // Reset while a spike is held: gen0 advances silently, gen1 spike is dropped.
        program_gen(0, 0, 3, 300);
        program_gen(1, 0, 0, 301);
        gens_used = 4'd2;
        gens_en   = 8'h03;
        @(negedge clk);
        unit_pulse = 1'b1;
        @(negedge clk);
        unit_pulse = 1'b0;
        out_a = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            #1;
            if (out_v) seen = 1;
            else @(negedge clk);
        end
        check_eq("abort_seen", 32'(seen), 32'd1);
        check_eq("abort_tag", 32'(out_tag), 32'd301);
        reset  = 1'b0;
        prog_v = 1'b1;
        #1;
        check_eq("abort_out_v", 32'(out_v), 32'd0);
        check_eq("abort_out_tag", 32'(out_tag), 32'd0);
        check_eq("abort_prog_a", 32'(prog_a), 32'd0);
        @(negedge clk);
        prog_v = 1'b0;
        reset  = 1'b1;
        m_tick[0] = 1;
        exp_tag = 0;
        run_sweep(0, 2, 0);
        check_eq("post_abort_tick0", 32'(m_tick[0]), 32'd2);
        run_sweep(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
